// File: rtl/sata_link_ctrl_pkg.sv
// Shared definitions for the SATA link bring-up sequencer and the AHCI port registers.
//   link_state_t : FSM state encodings (IDLE..FAIL), also reported on the debug state port
//   STATE_W      : width of the state encoding
//   CNT_W        : width of the retry/drop statistics counters
//   max4, clog2_min1 : elaboration-time helpers for sizing timers and counters
package sata_link_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    RESET     = 3'd1,
    PLL_WAIT  = 3'd2,
    START     = 3'd3,
    WAIT_LINK = 3'd4,
    READY     = 3'd5,
    BACKOFF   = 3'd6,
    FAIL      = 3'd7
  } link_state_t;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sata_link_ctrl_sync2.sv
// Two-flop synchroniser for one asynchronous PHY status bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, output clears to 0
//   d     : asynchronous input
//   q     : synchronised output (two clk edges of latency)
module sata_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sata_link_ctrl.sv
// Per-port SATA link bring-up sequencer: PHY reset, OOB start, lock/link watch,
// timeout/backoff retry and link status reporting.
//   clk, rst_n        : PHY clock, asynchronous active-low reset
//   enable            : port enable (level), 0 forces IDLE
//   force_reinit      : single-cycle COMRESET request, ignored in IDLE
//   plllock, CommInit, linkup : asynchronous PHY status, synchronised internally
//   phyreset          : PHY reset, active high
//   StartComm         : one-cycle OOB start pulse
//   link_ready        : link up, datapath may run
//   link_fail         : retry budget exhausted
//   state             : FSM state (debug)
//   retry_cnt         : failed attempts since last success/reinit (saturating)
//   drop_cnt          : READY link-loss events since reset (saturating)
// Build option SATA_LINK_CTRL_STATS_EN: when undefined, retry_cnt/drop_cnt read 0 and
// the internal retry counter is only as wide as the C_RETRY_MAX compare needs.
module sata_link_ctrl
  import sata_link_ctrl_pkg::*;
#(
  parameter int unsigned C_RESET_CYCLES = 16,
  parameter int unsigned C_PLL_TIMEOUT  = 4096,
  parameter int unsigned C_LINK_TIMEOUT = 65536,
  parameter int unsigned C_BACKOFF      = 8192,
  parameter int unsigned C_RETRY_MAX    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               force_reinit,
  input  logic               plllock,
  input  logic               CommInit,
  input  logic               linkup,
  output logic               phyreset,
  output logic               StartComm,
  output logic               link_ready,
  output logic               link_fail,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   retry_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int unsigned TMR_W =
    clog2_min1(max4(C_RESET_CYCLES, C_PLL_TIMEOUT, C_LINK_TIMEOUT, C_BACKOFF));
  localparam logic [TMR_W-1:0] RST_LD  = TMR_W'(C_RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] PLL_LD  = TMR_W'(C_PLL_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LINK_LD = TMR_W'(C_LINK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] BO_LD   = TMR_W'(C_BACKOFF - 1);

`ifdef SATA_LINK_CTRL_STATS_EN
  localparam int unsigned RETRY_W = CNT_W;
`else
  localparam int unsigned RETRY_W = clog2_min1(C_RETRY_MAX + 1);
`endif

  logic plllock_s, comminit_s, linkup_s, comminit_q, comminit_rise;
  link_state_t state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [RETRY_W-1:0] retry_q;
  logic retry_inc, retry_clr, retry_exhausted;

  sata_sync2 u_sync_pll  (.clk(clk), .rst_n(rst_n), .d(plllock),  .q(plllock_s));
  sata_sync2 u_sync_cinit(.clk(clk), .rst_n(rst_n), .d(CommInit), .q(comminit_s));
  sata_sync2 u_sync_link (.clk(clk), .rst_n(rst_n), .d(linkup),   .q(linkup_s));

  assign comminit_rise   = comminit_s & ~comminit_q;
  assign retry_exhausted = (C_RETRY_MAX != 0) && (32'(retry_q) >= C_RETRY_MAX);

  always_comb begin
    state_d   = state_q;
    tmr_d     = (tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RESET;
          tmr_d   = RST_LD;
        end
      end
      RESET: begin
        if (tmr_q == '0) begin
          state_d = PLL_WAIT;
          tmr_d   = PLL_LD;
        end
      end
      PLL_WAIT: begin
        if (plllock_s) begin
          state_d = START;
          tmr_d   = '0;
        end else if (tmr_q == '0) begin
          state_d   = BACKOFF;
          tmr_d     = BO_LD;
          retry_inc = 1'b1;
        end
      end
      START: begin
        state_d = WAIT_LINK;
        tmr_d   = LINK_LD;
      end
      WAIT_LINK: begin
        if (linkup_s) begin
          state_d   = READY;
          tmr_d     = '0;
          retry_clr = 1'b1;
        end else if (tmr_q == '0) begin
          state_d   = BACKOFF;
          tmr_d     = BO_LD;
          retry_inc = 1'b1;
        end
      end
      READY: begin
        if (!linkup_s) begin
          state_d = RESET;
          tmr_d   = RST_LD;
        end else if (comminit_rise) begin
          state_d = START;
          tmr_d   = '0;
        end
      end
      BACKOFF: begin
        if (tmr_q == '0) begin
          if (retry_exhausted) begin
            state_d = FAIL;
            tmr_d   = '0;
          end else begin
            state_d = RESET;
            tmr_d   = RST_LD;
          end
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
    // Host overrides are applied last so they win over the per-state transition.
    if (force_reinit && (state_q != IDLE)) begin
      state_d   = RESET;
      tmr_d     = RST_LD;
      retry_inc = 1'b0;
      retry_clr = 1'b1;
    end
    if (!enable) begin
      state_d   = IDLE;
      tmr_d     = '0;
      retry_inc = 1'b0;
      retry_clr = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they register in step with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      comminit_q <= 1'b0;
      phyreset   <= 1'b1;
      StartComm  <= 1'b0;
      link_ready <= 1'b0;
      link_fail  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      comminit_q <= comminit_s;
      phyreset   <= (state_d == IDLE) || (state_d == RESET);
      StartComm  <= (state_d == START);
      link_ready <= (state_d == READY);
      link_fail  <= (state_d == FAIL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= '0;
    end else if (retry_clr) begin
      retry_q <= '0;
    end else if (retry_inc && (retry_q != '1)) begin
      retry_q <= retry_q + 1'b1;
    end
  end

  assign state = state_q;

`ifdef SATA_LINK_CTRL_STATS_EN
  logic drop_inc;
  logic [CNT_W-1:0] drop_q;

  assign drop_inc = (state_q == READY) && !linkup_s && enable && !force_reinit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop_inc && (drop_q != '1)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign retry_cnt = retry_q;
  assign drop_cnt  = drop_q;
`else
  assign retry_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_sata_link_ctrl.sv
module tb_sata_link_ctrl;
  import sata_link_ctrl_pkg::*;

`ifdef SATA_LINK_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, enable, force_reinit, plllock, CommInit, linkup;
  logic phyreset, StartComm, link_ready, link_fail;
  logic [2:0] state;
  logic [7:0] retry_cnt, drop_cnt;

  sata_link_ctrl #(
    .C_RESET_CYCLES(4),
    .C_PLL_TIMEOUT (8),
    .C_LINK_TIMEOUT(16),
    .C_BACKOFF     (8),
    .C_RETRY_MAX   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .force_reinit(force_reinit),
    .plllock     (plllock),
    .CommInit    (CommInit),
    .linkup      (linkup),
    .phyreset    (phyreset),
    .StartComm   (StartComm),
    .link_ready  (link_ready),
    .link_fail   (link_fail),
    .state       (state),
    .retry_cnt   (retry_cnt),
    .drop_cnt    (drop_cnt)
  );

  // Expected output event: the full output tuple after a change, plus the number of
  // cycles the previous tuple was held (-1 = don't care).
  typedef struct {
    logic [2:0] st;
    logic       pr, sc, lr, lf;
    logic [7:0] rc, dc;
    int         after;
    int         id;
  } ev_t;

  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_retry = 0;
  int exp_drop = 0;
  int ev_id = 0;

  localparam logic [22:0] RESET_TUPLE = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};

  function automatic void push_exp(input link_state_t s, input int after);
    ev_t e;
    e.st    = s;
    e.pr    = (s == IDLE) || (s == RESET);
    e.sc    = (s == START);
    e.lr    = (s == READY);
    e.lf    = (s == FAIL);
    e.rc    = STATS ? 8'(exp_retry) : 8'd0;
    e.dc    = STATS ? 8'(exp_drop) : 8'd0;
    e.after = after;
    e.id    = ev_id;
    ev_id++;
    exp_q.push_back(e);
  endfunction

  // Monitor: every change of the output tuple is an event, popped and compared.
  initial begin
    logic [22:0] last, cur, expv;
    int cyc, last_cyc, dwell;
    ev_t e;
    last = RESET_TUPLE;
    cyc = 0;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {state, phyreset, StartComm, link_ready, link_fail, retry_cnt, drop_cnt};
      if (cur !== last) begin
        dwell = cyc - last_cyc;
        last_cyc = cyc;
        last = cur;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %h, required no output change", cur);
        end else begin
          e = exp_q.pop_front();
          expv = {e.st, e.pr, e.sc, e.lr, e.lf, e.rc, e.dc};
          if (cur !== expv) begin
            errors++;
            $display("FAIL event%0d outputs: got st=%0d pr=%b sc=%b lr=%b lf=%b rc=%0d dc=%0d, required st=%0d pr=%b sc=%b lr=%b lf=%b rc=%0d dc=%0d",
                     e.id, cur[22:20], cur[19], cur[18], cur[17], cur[16], cur[15:8], cur[7:0],
                     e.st, e.pr, e.sc, e.lr, e.lf, e.rc, e.dc);
          end
          if (e.after >= 0) begin
            checks++;
            if (dwell != e.after) begin
              errors++;
              $display("FAIL event%0d dwell: got %0d cycles, required %0d", e.id, dwell, e.after);
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input link_state_t s, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((state !== s) && (n < budget));
    checks++;
    if (state !== s) begin
      errors++;
      $display("FAIL wait_state: got state %0d after %0d cycles, required %0d", state, n, s);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [22:0] cur;
    cur = {state, phyreset, StartComm, link_ready, link_fail, retry_cnt, drop_cnt};
    checks++;
    if (cur !== RESET_TUPLE) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, cur, RESET_TUPLE);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; enable = 1'b0; force_reinit = 1'b0;
    plllock = 1'b0; CommInit = 1'b0; linkup = 1'b0;
    #1 rst_n = 1'b0;
    tick(3);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    tick(2);

    // Happy path: linkup 5 cycles after StartComm, link_ready 3 edges later.
    push_exp(RESET, -1);
    push_exp(PLL_WAIT, 4);
    push_exp(START, 1);
    push_exp(WAIT_LINK, 1);
    push_exp(READY, 7);
    enable = 1'b1; plllock = 1'b1;
    wait_state(START, 20);
    tick(5);
    linkup = 1'b1;
    wait_state(READY, 20);

    // Device COMINIT in READY: restart OOB without PHY reset.
    tick(2);
    push_exp(START, 5);
    push_exp(WAIT_LINK, 1);
    push_exp(READY, 1);
    CommInit = 1'b1;
    tick(1);
    CommInit = 1'b0;
    wait_state(START, 20);
    wait_state(READY, 20);

    // Link drop in READY: drop counted, full retrain.
    tick(2);
    exp_drop = 1;
    push_exp(RESET, 5);
    push_exp(PLL_WAIT, 4);
    push_exp(START, 1);
    push_exp(WAIT_LINK, 1);
    push_exp(READY, 1);
    linkup = 1'b0;
    wait_state(RESET, 10);
    linkup = 1'b1;
    wait_state(READY, 30);

    // Disable from READY, then abort in WAIT_LINK with enable=0 and force_reinit together.
    push_exp(IDLE, -1);
    enable = 1'b0; linkup = 1'b0;
    wait_state(IDLE, 5);
    tick(2);
    push_exp(RESET, -1);
    push_exp(PLL_WAIT, 4);
    push_exp(START, 1);
    push_exp(WAIT_LINK, 1);
    push_exp(IDLE, 4);
    enable = 1'b1;
    wait_state(WAIT_LINK, 20);
    tick(3);
    enable = 1'b0; force_reinit = 1'b1;
    wait_state(IDLE, 5);
    force_reinit = 1'b0;

    // Link timeouts exhaust the retry budget.
    tick(2);
    push_exp(RESET, -1);
    push_exp(PLL_WAIT, 4);
    push_exp(START, 1);
    push_exp(WAIT_LINK, 1);
    exp_retry = 1;
    push_exp(BACKOFF, 16);
    push_exp(RESET, 8);
    push_exp(PLL_WAIT, 4);
    push_exp(START, 1);
    push_exp(WAIT_LINK, 1);
    exp_retry = 2;
    push_exp(BACKOFF, 16);
    push_exp(FAIL, 8);
    enable = 1'b1;
    wait_state(FAIL, 200);

    // Recovery from FAIL via force_reinit, then a PLL timeout, then async reset mid-RESET.
    tick(3);
    exp_retry = 0;
    push_exp(RESET, -1);
    push_exp(PLL_WAIT, 4);
    exp_retry = 1;
    push_exp(BACKOFF, 8);
    push_exp(RESET, 8);
    plllock = 1'b0; force_reinit = 1'b1;
    tick(1);
    force_reinit = 1'b0;
    wait_state(BACKOFF, 40);
    wait_state(RESET, 20);
    tick(2);
    #2;
    exp_retry = 0;
    exp_drop = 0;
    push_exp(IDLE, -1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    plllock = 1'b1; linkup = 1'b1;
    push_exp(RESET, -1);
    push_exp(PLL_WAIT, 4);
    push_exp(START, 1);
    push_exp(WAIT_LINK, 1);
    push_exp(READY, 1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_state(READY, 30);

    // Repeated drops: drop counter saturates.
    for (int i = 0; i < 300; i++) begin
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
      push_exp(RESET, 3);
      push_exp(PLL_WAIT, 4);
      push_exp(START, 1);
      push_exp(WAIT_LINK, 1);
      push_exp(READY, 1);
      linkup = 1'b0;
      wait_state(RESET, 10);
      linkup = 1'b1;
      wait_state(READY, 30);
    end

    tick(5);
    checks++;
    if (drop_cnt !== (STATS ? 8'd255 : 8'd0)) begin
      errors++;
      $display("FAIL drop_saturation: got %0d, required %0d", drop_cnt, STATS ? 255 : 0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d events outstanding, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
